// File: rtl/packetmem_pkg.sv
// packetmem_pkg
// Shared definitions for the CPU packet-memory port.
// The controller also uses these load-size encodings.
//   xfer_sz_e : load size carried on transfer_sz (byte/half/word/reserved)
//   state_e   : buffer ownership states (IDLE, RUN, DONE)
//   sizeBytes : number of bytes a load size covers (0 for the reserved code)
package packetmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } xfer_sz_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [2:0] sizeBytes(input logic [1:0] sz);
        logic [2:0] n;
        case (sz)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/packetmem_extract.sv
// packetmem_extract
// Second pipeline stage of the load path. It joins the two BRAM words into a
// 64-bit big-endian window and shifts the addressed byte to the top. It then
// takes 8, 16 or 32 bits, zero-extends them and registers the result.
//   clk, rst   : clock, asynchronous active-low reset
//   i_valid    : a load occupies this stage
//   i_offset   : byte offset of the load inside word A
//   i_size     : load size (xfer_sz_e encoding)
//   i_oob      : load was flagged out of bounds; forces zero data
//   i_dataA/B  : BRAM words w and w+1
//   o_valid    : rd_valid, o_data: rd_data, o_oob: rd_oob
module packetmem_extract
    import packetmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_oob,
    input  logic [31:0] i_dataA,
    input  logic [31:0] i_dataB,
    output logic        o_valid,
    output logic        o_oob,
    output logic [31:0] o_data
);

    logic [63:0] w_window;
    logic [31:0] w_result;
    logic        r_valid;
    logic        r_oob;
    logic [31:0] r_data;

    // Left shift so the first addressed byte lands in bits 63:56. The result
    // is zero for the reserved size and for out-of-bounds loads.
    always_comb begin
        w_window = {i_dataA, i_dataB} << {i_offset, 3'b000};
        w_result = 32'd0;
        if (!i_oob) begin
            case (i_size)
                SZ_BYTE: w_result = {24'd0, w_window[63:56]};
                SZ_HALF: w_result = {16'd0, w_window[63:48]};
                SZ_WORD: w_result = w_window[63:32];
                default: w_result = 32'd0;
            endcase
        end
    end

    // The data register loads only on a valid load, so it keeps its last value between loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_oob   <= 1'b0;
            r_data  <= 32'd0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_oob  <= i_oob;
                r_data <= w_result;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_oob   = r_oob;
    assign o_data  = r_data;

endmodule

// File: rtl/packetmem_cpu_port.sv
// packetmem_cpu_port
// Packet-memory side of the CPU packet-buffer interface. It claims a filled
// buffer and raises mem_ready. It serves pipelined big-endian loads with a
// fixed latency of 2. It then latches the CPU verdict and releases the buffer
// with a buf_done pulse.
//   clk, rst                      : clock, asynchronous active-low reset
//   buf_ready, buf_len            : writer hands over a buffer of buf_len bytes
//   buf_done, buf_accept          : buffer released, with the verdict
//   mem_ready                     : packet available to the CPU
//   rd_en, rd_addr, transfer_sz   : CPU load request
//   accept, reject                : CPU verdict
//   rd_data, rd_valid, rd_oob     : load result
//   bram_rd_en, bram_addr_a/b     : dual-port BRAM read request (words w, w+1)
//   bram_data_a/b                 : BRAM read data, one cycle later
module packetmem_cpu_port
    import packetmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_ready,
    input  logic [ADDR_WIDTH+2:0] buf_len,
    output logic                  buf_done,
    output logic                  buf_accept,
    output logic                  mem_ready,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH+1:0] rd_addr,
    input  logic [1:0]            transfer_sz,
    input  logic                  accept,
    input  logic                  reject,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  rd_oob,
    output logic                  bram_rd_en,
    output logic [ADDR_WIDTH-1:0] bram_addr_a,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    input  logic [31:0]           bram_data_a,
    input  logic [31:0]           bram_data_b
);

    state_e                r_state;
    state_e                w_nextState;
    logic                  w_claim;
    logic                  w_verdictHit;
    logic [ADDR_WIDTH+2:0] r_lenBytes;
    logic                  r_verdict;

    logic                  w_rdGo;
    logic [ADDR_WIDTH+2:0] w_endAddr;
    logic                  w_oob;
    logic                  r_s1Valid;
    logic [1:0]            r_s1Offset;
    logic [1:0]            r_s1Size;
    logic                  r_s1Oob;

    // Next state and state-derived outputs. mem_ready and buf_done are
    // decoded from the state register, so they need no extra flops.
    always_comb begin
        w_nextState  = r_state;
        w_claim      = 1'b0;
        w_verdictHit = 1'b0;
        mem_ready    = 1'b0;
        buf_done     = 1'b0;
        buf_accept   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (buf_ready) begin
                    w_claim     = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                mem_ready = 1'b1;
                if (accept || reject) begin
                    w_verdictHit = 1'b1;
                    w_nextState  = ST_DONE;
                end
            end
            ST_DONE: begin
                buf_done    = 1'b1;
                buf_accept  = r_verdict;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State register, the packet length latched at claim, and the verdict.
    // If accept and reject arrive together, the packet is rejected.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_lenBytes <= '0;
            r_verdict  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_claim) begin
                r_lenBytes <= buf_len;
            end
            if (w_verdictHit) begin
                r_verdict <= accept & ~reject;
            end
        end
    end

    // Request stage. Port B reads the next word and wraps at the top of
    // memory. Any load that actually reaches the wrapped word lies past every
    // legal length, so the bound check flags it. The end address has one
    // spare bit, so the addition cannot overflow.
    assign w_rdGo      = rd_en && (r_state == ST_RUN);
    assign bram_rd_en  = w_rdGo;
    assign bram_addr_a = rd_addr[ADDR_WIDTH+1:2];
    assign bram_addr_b = bram_addr_a + ADDR_WIDTH'(1);
    assign w_endAddr   = {1'b0, rd_addr} + (ADDR_WIDTH+3)'(sizeBytes(transfer_sz));
    assign w_oob       = (transfer_sz == SZ_RSVD) || (w_endAddr > r_lenBytes);

    // Holds the load's offset, size and bound flag while the BRAM read is in
    // progress. Loads already in flight still finish after the state leaves RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid  <= 1'b0;
            r_s1Offset <= 2'd0;
            r_s1Size   <= 2'd0;
            r_s1Oob    <= 1'b0;
        end else begin
            r_s1Valid <= w_rdGo;
            if (w_rdGo) begin
                r_s1Offset <= rd_addr[1:0];
                r_s1Size   <= transfer_sz;
                r_s1Oob    <= w_oob;
            end
        end
    end

    packetmem_extract u_extract (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (r_s1Valid),
        .i_offset (r_s1Offset),
        .i_size   (r_s1Size),
        .i_oob    (r_s1Oob),
        .i_dataA  (bram_data_a),
        .i_dataB  (bram_data_b),
        .o_valid  (rd_valid),
        .o_oob    (rd_oob),
        .o_data   (rd_data)
    );

endmodule

// File: tb/tb_packetmem_cpu_port.sv
// tb_packetmem_cpu_port
// Directed and randomized bench for packetmem_cpu_port. The bench holds its
// own BRAM contents. It predicts each load from the packet byte stream and
// the latched length, and it tracks buffer ownership with a small phase model.
module tb_packetmem_cpu_port;

    localparam int AW = 10;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          buf_ready;
    logic [AW+2:0] buf_len;
    logic          buf_done;
    logic          buf_accept;
    logic          mem_ready;
    logic          rd_en;
    logic [AW+1:0] rd_addr;
    logic [1:0]    transfer_sz;
    logic          accept;
    logic          reject;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          rd_oob;
    logic          bram_rd_en;
    logic [AW-1:0] bram_addr_a;
    logic [AW-1:0] bram_addr_b;
    logic [31:0]   bram_data_a = 32'd0;
    logic [31:0]   bram_data_b = 32'd0;

    logic [31:0]   mem [NWORDS];

    int checks = 0;
    int errors = 0;

    // Bench-side model state: phase 0 = idle, 1 = owned by CPU, 2 = releasing
    int          phase = 0;
    int          mLen = 0;
    logic        mVerdict = 1'b0;
    logic        inReset = 1'b0;
    logic        s1V = 1'b0, outV = 1'b0;
    logic [31:0] s1D = 32'd0, outD = 32'd0;
    logic        s1O = 1'b0, outO = 1'b0;

    packetmem_cpu_port #(.ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .buf_ready   (buf_ready),
        .buf_len     (buf_len),
        .buf_done    (buf_done),
        .buf_accept  (buf_accept),
        .mem_ready   (mem_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .transfer_sz (transfer_sz),
        .accept      (accept),
        .reject      (reject),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_oob      (rd_oob),
        .bram_rd_en  (bram_rd_en),
        .bram_addr_a (bram_addr_a),
        .bram_addr_b (bram_addr_b),
        .bram_data_a (bram_data_a),
        .bram_data_b (bram_data_b)
    );

    always #5 clk = ~clk;

    // Dual-port BRAM with one cycle of read latency
    always @(posedge clk) begin
        if (bram_rd_en) begin
            bram_data_a <= mem[bram_addr_a];
            bram_data_b <= mem[bram_addr_b];
        end
    end

    // Packet byte k in network order
    function automatic logic [7:0] byteAt(input int k);
        logic [31:0] w;
        w = mem[(k / 4) % NWORDS];
        return w[8 * (3 - (k % 4)) +: 8];
    endfunction

    // Expected load result from the byte stream and the packet length
    function automatic void modelLoad(input int addr, input int sz, input int len,
                                      output logic [31:0] d, output logic o);
        int n;
        d = 32'd0;
        if (sz == 3) begin
            o = 1'b1;
            return;
        end
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        o = (addr + n > len);
        if (!o) begin
            for (int i = 0; i < n; i++) d = (d << 8) | 32'(byteAt(addr + i));
        end
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("rd_valid", 32'(rd_valid), 32'(outV));
        checkVal("mem_ready", 32'(mem_ready), 32'(phase == 1));
        checkVal("buf_done", 32'(buf_done), 32'(phase == 2));
        checkVal("buf_accept", 32'(buf_accept), 32'(phase == 2 && mVerdict));
        if (outV) begin
            checkVal("rd_data", rd_data, outD);
            checkVal("rd_oob", 32'(rd_oob), 32'(outO));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the clock edge,
    // then check outputs mid-cycle
    task automatic applyStimulus(input logic en, input int addr, input int sz,
                                 input logic rdy, input int len,
                                 input logic acc, input logic rej);
        logic        go;
        logic [31:0] d;
        logic        o;
        rd_en       = en;
        rd_addr     = (AW+2)'(addr);
        transfer_sz = 2'(sz);
        buf_ready   = rdy;
        buf_len     = (AW+3)'(len);
        accept      = acc;
        reject      = rej;
        #1;
        go = en && (phase == 1) && !inReset;
        checkVal("bram_rd_en", 32'(bram_rd_en), 32'(go));
        modelLoad(addr, sz, mLen, d, o);
        @(posedge clk);
        if (inReset) begin
            phase = 0; outV = 1'b0; s1V = 1'b0;
        end else begin
            outV = s1V; outD = s1D; outO = s1O;
            s1V = go; s1D = d; s1O = o;
            case (phase)
                0: if (rdy) begin mLen = len; phase = 1; end
                1: if (acc || rej) begin mVerdict = acc && !rej; phase = 2; end
                default: phase = 0;
            endcase
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idleCycles(input int n, input logic rdy, input int len);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, rdy, len, 1'b0, 1'b0);
    endtask

    task automatic randomLoads(input int n, input int maxAddr, input int len);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'($urandom_range(0, 1)) | 1'(i % 3 == 0),
                          int'($urandom_range(0, maxAddr)), int'($urandom_range(0, 3)),
                          1'b1, len, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int rlen;
        for (int i = 0; i < NWORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;

        rst = 1'b0; inReset = 1'b1;
        rd_en = 1'b0; rd_addr = '0; transfer_sz = 2'd0;
        buf_ready = 1'b0; buf_len = '0; accept = 1'b0; reject = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("reset_mem_ready", 32'(mem_ready), 32'd0);
        checkVal("reset_buf_done", 32'(buf_done), 32'd0);
        checkVal("reset_buf_accept", 32'(buf_accept), 32'd0);
        checkVal("reset_rd_valid", 32'(rd_valid), 32'd0);
        checkVal("reset_rd_oob", 32'(rd_oob), 32'd0);
        checkVal("reset_rd_data", rd_data, 32'd0);
        rst = 1'b1; inReset = 1'b0;
        idleCycles(1, 1'b0, 0);

        // Loads while idle are ignored
        applyStimulus(1'b1, 4, 2, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
        idleCycles(2, 1'b0, 0);

        // Claim a 64-byte packet, then back-to-back directed loads
        applyStimulus(1'b0, 0, 0, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 0, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 1, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 2, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 8, 3, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 62, 1, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 61, 2, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 4094, 2, 1'b1, 64, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 64);
        randomLoads(40, 70, 64);

        // Accept with a load issued in the same cycle, then release
        applyStimulus(1'b1, 5, 2, 1'b1, 64, 1'b1, 1'b0);
        applyStimulus(1'b1, 6, 1, 1'b0, 64, 1'b0, 1'b0);
        idleCycles(2, 1'b0, 0);

        // Short packet bounds, then accept and reject together
        applyStimulus(1'b0, 0, 0, 1'b1, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 2, 1'b1, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 4, 1, 1'b1, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 0, 1'b1, 6, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 1, 1'b1, 6, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 6);
        randomLoads(20, 10, 6);
        applyStimulus(1'b0, 0, 0, 1'b1, 6, 1'b1, 1'b1);
        idleCycles(3, 1'b0, 0);

        // Random lengths with random loads, ended by a reject
        for (int p = 0; p < 3; p++) begin
            rlen = int'($urandom_range(0, 40));
            applyStimulus(1'b0, 0, 0, 1'b1, rlen, 1'b0, 1'b0);
            randomLoads(25, 44, rlen);
            applyStimulus(1'b0, 0, 0, 1'b1, rlen, 1'b0, 1'b1);
            idleCycles(3, 1'b0, 0);
        end

        // Reset during RUN with loads still in the pipeline
        applyStimulus(1'b0, 0, 0, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 2, 1'b1, 64, 1'b0, 1'b0);
        rd_en = 1'b1; rd_addr = 12'd4; transfer_sz = 2'd2;
        @(posedge clk);
        #1;
        rst = 1'b0; inReset = 1'b1;
        rd_en = 1'b0; buf_ready = 1'b0;
        #1;
        checkVal("midrst_mem_ready", 32'(mem_ready), 32'd0);
        checkVal("midrst_buf_done", 32'(buf_done), 32'd0);
        checkVal("midrst_buf_accept", 32'(buf_accept), 32'd0);
        checkVal("midrst_rd_valid", 32'(rd_valid), 32'd0);
        checkVal("midrst_rd_oob", 32'(rd_oob), 32'd0);
        checkVal("midrst_rd_data", rd_data, 32'd0);
        checkVal("midrst_bram_rd_en", 32'(bram_rd_en), 32'd0);
        phase = 0; outV = 1'b0; s1V = 1'b0;
        idleCycles(3, 1'b0, 0);
        rst = 1'b1; inReset = 1'b0;
        idleCycles(3, 1'b0, 0);

        // A new claim after reset behaves normally
        applyStimulus(1'b0, 0, 0, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 1, 0, 1'b1, 64, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 2, 1'b1, 64, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        idleCycles(3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
